// File: rtl/uart_rx_buffered_if.sv
// Consumer-side and line-side signals of the buffered UART receiver.
// The receiver connects through the slave modport; whatever drives the
// serial line and drains the FIFO connects through the master modport.
interface uart_rx_buffered_if #(
   parameter int DATABITS   = 8,
   parameter int FIFO_DEPTH = 4
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic                rx_data;
   logic [DATABITS-1:0] rx_data_out;
   logic                rx_valid;
   logic                rx_ready;
   logic                parity_error;
   logic                stop_error;
   logic                overrun;
   logic [CW-1:0]       fifo_count;
   logic                rx_busy;

   modport slave (
      input  rx_data, rx_ready,
      output rx_data_out, rx_valid, parity_error, stop_error, overrun,
             fifo_count, rx_busy
   );

   modport master (
      output rx_data, rx_ready,
      input  rx_data_out, rx_valid, parity_error, stop_error, overrun,
             fifo_count, rx_busy
   );
endinterface

// File: rtl/uart_rx_buffered.sv
// UART receive channel: 16x oversampled bit recovery with a start-bit
// glitch filter, parity and stop checks, and a small FIFO of
// {data, parity error, stop error} entries drained over valid/ready.
// DATABITS is assumed to be at least 2.
module uart_rx_buffered #(
   parameter int SYS_FREQ    = 10_000_000,
   parameter int BAUD_RATE   = 9600,
   parameter int DATABITS    = 8,
   parameter int PARITY_EN   = 1,
   parameter int PARITY_TYPE = 0,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic              clk,
   input  logic              reset,
   uart_rx_buffered_if.slave bus
);

   localparam int DIV = SYS_FREQ / (BAUD_RATE * 16);
   localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int CW  = AW + 1;
   localparam int BW  = $clog2(DATABITS + 1);
   localparam int EW  = DATABITS + 2;

   localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
   localparam logic [BW-1:0] LAST_BIT  = BW'(DATABITS - 1);
   localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
   localparam logic          ODD_PAR   = (PARITY_TYPE != 0);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   // Input synchroniser and tick generator
   logic [1:0]          r_sync;
   logic                w_rxs;
   logic [DW-1:0]       r_div;
   logic                w_tick;
   logic                w_start;

   // Receive FSM
   state_t              r_state;
   logic [3:0]          r_cnt;
   logic [BW-1:0]       r_bitn;
   logic [DATABITS-1:0] r_shift;
   logic                r_perr;
   logic                r_serr;
   logic                r_armed;
   logic                r_push;
   logic                r_busy;

   // FIFO
   logic [EW-1:0]       r_mem [FIFO_DEPTH];
   logic [AW-1:0]       r_wp;
   logic [AW-1:0]       r_rp;
   logic [CW-1:0]       r_count;
   logic                r_valid;
   logic [DATABITS-1:0] r_head_data;
   logic                r_head_perr;
   logic                r_head_serr;
   logic                r_ovr;

   logic [EW-1:0]       w_entry_in;
   logic                w_pop;
   logic                w_full;
   logic                w_wr;
   logic                w_ovr;
   logic [AW-1:0]       w_rp_next;
   logic [CW-1:0]       w_count_next;
   logic [EW-1:0]       w_head_next;

   assign w_rxs   = r_sync[1];
   assign w_tick  = (r_div == DIV_LAST);
   assign w_start = (r_state == S_IDLE) && r_armed && !w_rxs;

   // Two-flop synchroniser; resets to the idle (high) line level
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sync <= 2'b11;
      end else begin
         r_sync <= {r_sync[0], bus.rx_data};
      end
   end

   // Oversampling tick divider, re-phased to the start edge on leaving IDLE
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_div <= '0;
      end else if (w_start || w_tick) begin
         r_div <= '0;
      end else begin
         r_div <= r_div + DW'(1);
      end
   end

   // Receive FSM: start validation, data/parity/stop sampling, push strobe
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_bitn  <= '0;
         r_shift <= '0;
         r_perr  <= 1'b0;
         r_serr  <= 1'b0;
         r_armed <= 1'b0;
         r_push  <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_push <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_rxs) begin
                  r_armed <= 1'b1;
               end else if (r_armed) begin
                  r_state <= S_START;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
               end
            end
            S_START: begin
               if (w_tick) begin
                  if (r_cnt == 4'd7) begin
                     if (w_rxs) begin
                        // Line back high at mid-bit: treat as a glitch
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                     end else begin
                        r_state <= S_DATA;
                        r_cnt   <= '0;
                        r_bitn  <= '0;
                        r_perr  <= 1'b0;
                     end
                  end else begin
                     r_cnt <= r_cnt + 4'd1;
                  end
               end
            end
            S_DATA: begin
               if (w_tick) begin
                  r_cnt <= r_cnt + 4'd1;
                  if (r_cnt == 4'd15) begin
                     r_shift <= {w_rxs, r_shift[DATABITS-1:1]};
                     if (r_bitn == LAST_BIT) begin
                        r_state <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
                     end else begin
                        r_bitn <= r_bitn + BW'(1);
                     end
                  end
               end
            end
            S_PARITY: begin
               if (w_tick) begin
                  r_cnt <= r_cnt + 4'd1;
                  if (r_cnt == 4'd15) begin
                     r_perr  <= (^r_shift) ^ w_rxs ^ ODD_PAR;
                     r_state <= S_STOP;
                  end
               end
            end
            S_STOP: begin
               if (w_tick) begin
                  r_cnt <= r_cnt + 4'd1;
                  if (r_cnt == 4'd15) begin
                     // Leave at mid-stop so a back-to-back start edge is caught;
                     // a low stop bit disarms detection until the line rises
                     r_serr  <= ~w_rxs;
                     r_push  <= 1'b1;
                     r_armed <= w_rxs;
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign w_entry_in   = {r_shift, r_perr, r_serr};
   assign w_pop        = r_valid && bus.rx_ready;
   assign w_full       = (r_count == FULL_CNT);
   assign w_wr         = r_push && (!w_full || w_pop);
   assign w_ovr        = r_push && w_full && !w_pop;
   assign w_count_next = r_count + CW'(w_wr) - CW'(w_pop);

   // Next head entry: memory at the next read pointer, or the incoming
   // entry when it lands exactly there (push into an empty or draining FIFO)
   always_comb begin
      w_rp_next = r_rp;
      if (w_pop) begin
         w_rp_next = r_rp + AW'(1);
      end
      w_head_next = r_mem[w_rp_next];
      if (w_wr && (r_wp == w_rp_next)) begin
         w_head_next = w_entry_in;
      end
   end

   // FIFO storage array
   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_mem[r_wp] <= w_entry_in;
      end
   end

   // FIFO pointers, occupancy, registered head and overrun pulse
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wp        <= '0;
         r_rp        <= '0;
         r_count     <= '0;
         r_valid     <= 1'b0;
         r_head_data <= '0;
         r_head_perr <= 1'b0;
         r_head_serr <= 1'b0;
         r_ovr       <= 1'b0;
      end else begin
         if (w_wr) begin
            r_wp <= r_wp + AW'(1);
         end
         r_rp    <= w_rp_next;
         r_count <= w_count_next;
         r_valid <= (w_count_next != '0);
         r_ovr   <= w_ovr;
         if (w_count_next != '0) begin
            {r_head_data, r_head_perr, r_head_serr} <= w_head_next;
         end
      end
   end

   assign bus.rx_data_out  = r_head_data;
   assign bus.rx_valid     = r_valid;
   assign bus.parity_error = r_head_perr;
   assign bus.stop_error   = r_head_serr;
   assign bus.overrun      = r_ovr;
   assign bus.fifo_count   = r_count;
   assign bus.rx_busy      = r_busy;

endmodule

// File: doc/uart_rx_buffered.md
Name: uart_rx_buffered

Overview:
- Standalone UART receive channel with 16x oversampling, a start-bit glitch filter, parity and stop checking, and a small receive FIFO.
- Each FIFO entry holds one received byte plus its error flags; the consumer drains entries over a valid/ready handshake.
- Sits between the serial line (or a loopback from the UART transmitter) and a host consumer that cannot always take a byte on the cycle it is received.

Parameters:
- SYS_FREQ, 10_000_000: system clock frequency in Hz.
- BAUD_RATE, 9600: line rate in bit/s.
- DATABITS, 8: data bits per frame, sent LSB first.
- PARITY_EN, 1: 1 means a parity bit follows the data bits; 0 means no parity bit.
- PARITY_TYPE, 0: 0 selects even parity, 1 selects odd parity.
- FIFO_DEPTH, 4: number of entries; must be a power of 2 and at least 2.

Ports:
- clk  in  1  system clock; everything is clocked on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- rx_data  in  1  serial input; idles high; asynchronous to clk.
- rx_data_out  out  DATABITS  data byte of the FIFO head entry.
- rx_valid  out  1  FIFO is non-empty; head entry is presented.
- rx_ready  in  1  consumer accepts the head entry; a pop occurs when rx_valid and rx_ready are both high.
- parity_error  out  1  parity-error flag of the head entry; 0 when PARITY_EN=0.
- stop_error  out  1  stop-error flag of the head entry (stop bit sampled low).
- overrun  out  1  one-cycle pulse when a completed frame is dropped because the FIFO is full.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  number of occupied entries.
- rx_busy  out  1  receive FSM is in any state other than IDLE.

Behaviour:
- Reset (reset=0): every output and all state clear immediately. rx_data_out, rx_valid, parity_error, stop_error, overrun, fifo_count and rx_busy are all 0. FSM goes to IDLE, the FIFO empties, and both synchroniser flops are set to 1. Reset asserted mid-frame abandons the frame; nothing is pushed.
- Input path: rx_data passes through a 2-flop synchroniser; all logic uses the synchronised value rxs.
- Tick generator:
  - DIV = SYS_FREQ / (BAUD_RATE*16), integer division; 65 at the defaults.
  - A free-running counter pulses tick for 1 clk every DIV clocks.
  - The counter restarts at 0 when the FSM leaves IDLE, so sample phase is referenced to the start edge.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - A per-bit tick counter cnt (0..15) counts ticks within the current bit.
- IDLE:
  - Start detection is armed only after rxs has been seen high for at least 1 clk.
  - An armed rxs=0 moves the FSM to START with cnt=0.
- START:
  - At cnt=7 (mid-bit), if rxs=1 the low was a glitch: return to IDLE, push nothing.
  - Otherwise reset cnt to 0 and go to DATA.
- DATA:
  - Sample rxs at every cnt=15 and shift it in LSB first.
  - After DATABITS samples, go to PARITY if PARITY_EN=1, otherwise go to STOP.
- PARITY:
  - Sample at cnt=15.
  - perr = (XOR of data bits) XOR (sampled parity bit) XOR PARITY_TYPE; a nonzero result sets the flag.
- STOP:
  - Sample at cnt=15. serr = ~rxs.
  - Go to IDLE on the same clk; there is no wait for the end of the stop bit, so back-to-back frames are received.
  - If serr=1, start detection is disarmed until rxs is seen high.
- FIFO push:
  - On the clk after the stop sample, the entry {data, perr, serr} is pushed.
  - If fifo_count==FIFO_DEPTH and there is no pop on the same clk, the entry is dropped and overrun pulses for exactly 1 clk.
  - A push and a pop on the same clk while full is legal: the pop frees the slot, the push is accepted, and fifo_count is unchanged.
- FIFO outputs:
  - Registered head. rx_valid rises 1 clk after a push into an empty FIFO.
  - rx_data_out, parity_error and stop_error are stable while rx_valid=1 and rx_ready=0.
  - Pop when empty is ignored. Read and write pointers wrap modulo FIFO_DEPTH.
  - fifo_count is incremented on a push, decremented on a pop, and unchanged on a simultaneous push and pop.
- Bit period: 16*DIV clocks, which is 1040 clk at the defaults.

Test Plan:
- Clean frame, rx_ready=1: drive 0xF5 LSB first at 1040 clk/bit, parity bit 0 (even), stop bit 1 -> rx_valid pulses with rx_data_out=0xF5, parity_error=0, stop_error=0, fifo_count returns to 0.
- Bad parity: drive 0xA3 with parity bit 1 (correct even parity is 0) -> entry with rx_data_out=0xA3, parity_error=1, stop_error=0.
- Framing error: drive 0x3C with stop bit 0, hold the line low 3 bit times, then release high -> one entry with stop_error=1 and no second frame; a following 0x55 frame is received cleanly.
- Start glitch: pull rx_data low for 4 clk, then high -> rx_busy asserts then returns to 0 without a push; fifo_count stays 0; no overrun.
- Overflow: rx_ready=0, send frames 0x01..0x05 back-to-back -> fifo_count=4 and overrun pulses once after frame 5. Then set rx_ready=1 -> pops 0x01, 0x02, 0x03, 0x04 in order, then rx_valid=0.
- Reset mid-frame: assert reset low for 5 clk during the 4th data bit of a frame -> all outputs 0 immediately. After release, a clean 0x96 frame is received correctly with no spurious entry.
